// File: rtl/prc_pkg.sv
// Shared constants and helpers for the pipeline result collector.
// Default geometry, the accumulator saturation value and the occupancy-width helper.
package prc_pkg;

  localparam int PRC_DATA_W  = 6;
  localparam int PRC_LATENCY = 3;
  localparam int PRC_DEPTH   = 4;
  localparam int PRC_SUM_W   = 12;

  localparam logic [PRC_SUM_W-1:0] PRC_SUM_MAX = {PRC_SUM_W{1'b1}};

  // Occupancy needs one extra bit so that a full FIFO (level == DEPTH) is representable.
  function automatic int prc_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prc_sync_fifo.sv
// Parameterised synchronous FIFO with occupancy, full and empty.
// The head word is presented combinationally from storage and forced to 0 while empty.
module prc_sync_fifo
  import prc_pkg::*;
#(
  parameter int W     = PRC_DATA_W,
  parameter int DEPTH = PRC_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            push,
  input  logic                            pop,
  input  logic [W-1:0]                    wdata,
  output logic [W-1:0]                    rdata,
  output logic [prc_level_w(DEPTH)-1:0]   level,
  output logic                            full,
  output logic                            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = prc_level_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Next-state for storage, pointers and occupancy; clr wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == {LW{1'b0}});
  assign rdata = empty ? {W{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/pipe_result_collector.sv
// Collects valid results from the un-flagged arithmetic pipeline into a FIFO and drains them.
// Build option PRC_STATS_EN adds the saturating result sum and the result counter.
module pipe_result_collector
  import prc_pkg::*;
#(
  parameter int DATA_W  = PRC_DATA_W,
  parameter int LATENCY = PRC_LATENCY,
  parameter int DEPTH   = PRC_DEPTH,
  parameter int SUM_W   = PRC_SUM_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  input  logic [DATA_W-1:0]              pipe_data,
  input  logic                           flush,
  input  logic                           res_ready,
  output logic                           res_valid,
  output logic [DATA_W-1:0]              res_data,
  output logic [prc_level_w(DEPTH)-1:0]  fifo_level,
  output logic                           drop_err,
  output logic [SUM_W-1:0]               acc_sum,
  output logic [7:0]                     result_count
);

  logic [LATENCY-1:0] vd_q, vd_d;
  logic               drop_err_q, drop_err_d;
  logic               cap;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;

  // Valid delay line mirroring the arithmetic pipeline latency.
  always_comb begin
    vd_d = vd_q;
    if (flush) begin
      vd_d = {LATENCY{1'b0}};
    end else begin
      vd_d[0] = issue_valid;
      for (int i = 1; i < LATENCY; i++) begin
        vd_d[i] = vd_q[i-1];
      end
    end
  end

  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign cap  = vd_q[LATENCY-1];
  assign pop  = res_valid & res_ready & ~flush;
  assign push = cap & (~full | pop) & ~flush;

  // Sticky overflow flag.
  always_comb begin
    drop_err_d = drop_err_q;
    if (flush) begin
      drop_err_d = 1'b0;
    end else if (cap & full & ~pop) begin
      drop_err_d = 1'b1;
    end else begin
      drop_err_d = drop_err_q;
    end
  end

  // Delay line and overflow flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vd_q       <= {LATENCY{1'b0}};
      drop_err_q <= 1'b0;
    end else begin
      vd_q       <= vd_d;
      drop_err_q <= drop_err_d;
    end
  end

  prc_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (pipe_data),
    .rdata (res_data),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign res_valid = ~empty;
  assign drop_err  = drop_err_q;

`ifdef PRC_STATS_EN
  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [7:0]       result_count_q, result_count_d;
  logic [SUM_W:0]   sum_wide;

  // Saturating sum and wrapping count of words actually pushed.
  always_comb begin
    sum_wide       = {1'b0, acc_sum_q} + (SUM_W+1)'(pipe_data);
    acc_sum_d      = acc_sum_q;
    result_count_d = result_count_q;
    if (flush) begin
      acc_sum_d      = {SUM_W{1'b0}};
      result_count_d = 8'd0;
    end else if (push) begin
      acc_sum_d      = sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
      result_count_d = result_count_q + 8'd1;
    end else begin
      acc_sum_d      = acc_sum_q;
      result_count_d = result_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_q      <= {SUM_W{1'b0}};
      result_count_q <= 8'd0;
    end else begin
      acc_sum_q      <= acc_sum_d;
      result_count_q <= result_count_d;
    end
  end

  assign acc_sum      = acc_sum_q;
  assign result_count = result_count_q;
`else
  assign acc_sum      = {SUM_W{1'b0}};
  assign result_count = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_result_collector.sv
// Randomised bench for pipe_result_collector against a queue-based reference model.
// Statistics expectations fall back to 0 when PRC_STATS_EN is not defined.
module tb_pipe_result_collector;

  localparam int DW     = 6;
  localparam int LAT    = 3;
  localparam int DEPTH  = 4;
  localparam int SW     = 12;
  localparam int SMAX   = 4095;
  localparam int NSCHED = 8192;
`ifdef PRC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [DW-1:0] pipe_data;
  logic          flush;
  logic          res_ready;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [2:0]    fifo_level;
  logic          drop_err;
  logic [SW-1:0] acc_sum;
  logic [7:0]    result_count;

  always #5 clk = ~clk;

  pipe_result_collector #(
    .DATA_W  (DW),
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .SUM_W   (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .pipe_data    (pipe_data),
    .flush        (flush),
    .res_ready    (res_ready),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .fifo_level   (fifo_level),
    .drop_err     (drop_err),
    .acc_sum      (acc_sum),
    .result_count (result_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Arithmetic pipeline stand-in: the result due for capture at a given edge.
  bit            sched_v [NSCHED];
  logic [DW-1:0] sched_d [NSCHED];

  // Reference model state.
  logic [DW-1:0] mq[$];
  bit            m_drop;
  int            m_sum;
  int            m_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("res_valid",    int'(res_valid),    (mq.size() != 0) ? 1 : 0);
    chk("res_data",     int'(res_data),     (mq.size() != 0) ? int'(mq[0]) : 0);
    chk("fifo_level",   int'(fifo_level),   mq.size());
    chk("drop_err",     int'(drop_err),     int'(m_drop));
    chk("acc_sum",      int'(acc_sum),      STATS ? m_sum : 0);
    chk("result_count", int'(result_count), STATS ? m_cnt : 0);
  endtask

  task automatic model_clear();
    mq.delete();
    m_drop = 1'b0;
    m_sum  = 0;
    m_cnt  = 0;
  endtask

  // Apply the behaviour of the edge just taken, given the inputs held across it.
  task automatic model_edge(input bit fl, input bit rdy);
    bit cap;
    bit pop;
    bit push;
    int sz;
    if (fl) begin
      model_clear();
      for (int k = cyc; k <= cyc + LAT; k++) sched_v[k] = 1'b0;
    end else begin
      cap = sched_v[cyc];
      sz  = mq.size();
      pop = (sz > 0) && rdy;
      if (pop) void'(mq.pop_front());
      push = cap && ((sz < DEPTH) || pop);
      if (push) begin
        mq.push_back(sched_d[cyc]);
        m_sum = m_sum + int'(sched_d[cyc]);
        if (m_sum > SMAX) m_sum = SMAX;
        m_cnt = (m_cnt + 1) % 256;
      end else if (cap) begin
        m_drop = 1'b1;
      end
    end
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, check 1 time unit later.
  task automatic step(input bit iv, input logic [DW-1:0] val, input bit rdy, input bit fl);
    int e;
    e           = cyc + 1;
    issue_valid = iv;
    res_ready   = rdy;
    flush       = fl;
    pipe_data   = sched_v[e] ? sched_d[e] : DW'($urandom);
    if (iv) begin
      sched_v[e + LAT] = 1'b1;
      sched_d[e + LAT] = val;
    end
    @(posedge clk);
    cyc++;
    model_edge(fl, rdy);
    #1 check_outputs();
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; everything in flight is lost.
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    model_clear();
    for (int k = cyc; k <= cyc + LAT + 4; k++) sched_v[k] = 1'b0;
    check_outputs();
    issue_valid = 1'b0;
    flush       = 1'b0;
    res_ready   = 1'b1;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    flush       = 1'b0;
    res_ready   = 1'b0;
    pipe_data   = DW'($urandom);
    model_clear();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Idle with garbage on the pipeline output.
    repeat (10) step(1'b0, 6'd0, 1'b0, 1'b0);

    // Single result.
    step(1'b1, 6'd21, 1'b1, 1'b0);
    repeat (6) step(1'b0, 6'd0, 1'b1, 1'b0);

    // Overflow: six results into four entries, then drain.
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    repeat (5) step(1'b0, 6'd0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 6'd0, 1'b1, 1'b0);

    // Full FIFO with a pop in the capture cycle: no drop.
    step(1'b0, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(10 + i), 1'b0, 1'b0);
    repeat (LAT - 1) step(1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 6'd0, 1'b1, 1'b0);

    // Saturation: 70 results of 63.
    step(1'b0, 6'd0, 1'b1, 1'b1);
    repeat (70) step(1'b1, 6'd63, 1'b1, 1'b0);
    repeat (6) step(1'b0, 6'd0, 1'b1, 1'b0);

    // Flush with two queued and two in flight.
    step(1'b0, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(30 + i), 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 6'd0, 1'b1, 1'b0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(40 + i), 1'b0, 1'b0);
    repeat (3) step(1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b1, 1'b0);
    reset_mid();
    repeat (6) step(1'b0, 6'd0, 1'b1, 1'b0);

    // Random traffic: a congested phase, then a mostly-ready phase.
    for (int i = 0; i < 800; i++) begin
      step(1'b1 & ($urandom_range(0, 1) == 1),
           DW'($urandom),
           (i < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 49) == 0));
      if (i == 550) reset_mid();
    end
    repeat (8) step(1'b0, 6'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
